// File: rtl/axi_lite_manager_bridge.sv
// ---------------------------------------------------------------------------
// axi_lite_manager_bridge
//
// Converts a single-request user port (CPU or test sequencer) into AXI5-Lite
// manager transactions. Only one transaction is in flight at a time. Writes
// use AW/W/B and reads use AR/R. The result is returned on a valid/ready
// response port as data, resp and direction.
//
// Every transaction carries an ID tag that alternates per transaction. If the
// returned BID/RID does not match the issued tag, the response is reported
// as SLVERR (3'b010), whatever the worker actually answered.
//
// Ports
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   req_*                user request (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                user response (valid/ready, rdata, resp, is_write)
//   AW*/W*/B*            AXI write address / data / response channels
//   AR*/R*               AXI read address / data channels
//
// State table
//   state    | meaning
//   IDLE     | req_ready high, waiting for a user request
//   WR_ISSUE | AWVALID/WVALID outstanding, each drops on its own handshake
//   WR_RESP  | BREADY high, waiting for the write response
//   RD_ISSUE | ARVALID outstanding
//   RD_RESP  | RREADY high, waiting for read data
//   RSP      | rsp_valid high, fields frozen until rsp_ready
// ---------------------------------------------------------------------------
module axi_lite_manager_bridge #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int ID_W   = 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [2:0]        rsp_resp,
  output logic              rsp_is_write,

  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [ID_W-1:0]   AWID,

  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,

  input  logic              BVALID,
  output logic              BREADY,
  input  logic [2:0]        BRESP,
  input  logic [ID_W-1:0]   BID,

  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [ID_W-1:0]   ARID,

  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [2:0]        RRESP,
  input  logic [ID_W-1:0]   RID
);

  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_RESP,
    RSP
  } state_t;

  state_t          state;
  logic            aw_done;
  logic            w_done;
  logic            is_write;
  logic [ID_W-1:0] tag;
  logic [ID_W-1:0] issued_id;

  // A channel counts as finished if it completed earlier or completes on
  // this edge. This lets a same-cycle final handshake move straight on.
  logic aw_fin;
  logic w_fin;

  assign aw_fin = aw_done | (AWVALID & AWREADY);
  assign w_fin  = w_done  | (WVALID  & WREADY);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= '0;
      rsp_is_write <= 1'b0;
      AWVALID      <= 1'b0;
      AWADDR       <= '0;
      AWID         <= '0;
      WVALID       <= 1'b0;
      WDATA        <= '0;
      WSTRB        <= '0;
      BREADY       <= 1'b0;
      ARVALID      <= 1'b0;
      ARADDR       <= '0;
      ARID         <= '0;
      RREADY       <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      is_write     <= 1'b0;
      tag          <= '0;
      issued_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            AWADDR    <= req_addr;
            ARADDR    <= req_addr;
            WDATA     <= req_wdata;
            WSTRB     <= req_wstrb;
            AWID      <= tag;
            ARID      <= tag;
            issued_id <= tag;
            is_write  <= req_we;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (req_we) begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_ISSUE;
            end else begin
              ARVALID <= 1'b1;
              state   <= RD_ISSUE;
            end
          end else begin
            // Also the path that raises req_ready one cycle after reset or
            // after a completed response.
            req_ready <= 1'b1;
          end
        end

        WR_ISSUE: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (BVALID && BREADY) begin
            BREADY       <= 1'b0;
            rsp_resp     <= (BID == issued_id) ? BRESP : RESP_SLVERR;
            rsp_rdata    <= '0;
            rsp_is_write <= is_write;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RD_ISSUE: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (RVALID && RREADY) begin
            RREADY       <= 1'b0;
            rsp_resp     <= (RID == issued_id) ? RRESP : RESP_SLVERR;
            rsp_rdata    <= RDATA;
            rsp_is_write <= is_write;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            tag       <= tag + ID_W'(1);
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_manager_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_manager_bridge
//
// The bench works in three parts:
//   - A directed vector table. Each record holds the request, the worker
//     timing and answer, and the expected response and latency.
//   - A hand-written sequence for a reset in the middle of a write.
//   - Randomised transactions. Their expectations come from a small model.
//
// The worker and the user side are driven on the falling edge. The bridge
// samples on the rising edge, so every sample is taken away from the active
// clock edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_manager_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 1;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK;
  logic              ARESETn;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid, rsp_ready, rsp_is_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [2:0]        rsp_resp;
  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [ID_W-1:0]   AWID;
  logic              WVALID, WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [2:0]        BRESP;
  logic [ID_W-1:0]   BID;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [ID_W-1:0]   ARID;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [2:0]        RRESP;
  logic [ID_W-1:0]   RID;

  axi_lite_manager_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_is_write(rsp_is_write),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_w, w_w, b_w, ar_w, r_w;
    logic [2:0]  resp;
    logic [31:0] rdata;
    logic        bad_id;
    int          hold;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_resp;
    logic        exp_wr;
    int          exp_lat;
    logic        exp_id;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
    input int aw_w, input int w_w, input int b_w, input int ar_w, input int r_w,
    input logic [2:0] resp, input logic [31:0] rdata, input logic bad_id, input int hold,
    input logic [31:0] exp_rdata, input logic [2:0] exp_resp, input logic exp_wr,
    input int exp_lat, input logic exp_id);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw_w = aw_w; v.w_w = w_w; v.b_w = b_w; v.ar_w = ar_w; v.r_w = r_w;
    v.resp = resp; v.rdata = rdata; v.bad_id = bad_id; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_wr = exp_wr;
    v.exp_lat = exp_lat; v.exp_id = exp_id;
    return v;
  endfunction

  // Reference model. A mismatched ID reports SLVERR. Writes return zero
  // data. Each channel wait adds straight to the minimum 3-cycle round trip,
  // and AW/W overlap, so only the slower of the two counts.
  function automatic vec_t model(input vec_t v, input logic tag);
    int mx;
    mx          = (v.aw_w > v.w_w) ? v.aw_w : v.w_w;
    v.exp_id    = tag;
    v.exp_wr    = v.we;
    v.exp_rdata = v.we ? 32'h0 : v.rdata;
    v.exp_resp  = v.bad_id ? 3'b010 : v.resp;
    v.exp_lat   = v.we ? (3 + mx + v.b_w) : (3 + v.ar_w + v.r_w);
    return v;
  endfunction

  // ---------------- worker model + protocol monitor ----------------
  int         cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [2:0] cfg_resp;
  logic [31:0] cfg_rdata;
  logic       cfg_bad;
  int         aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit         wr_aw_got, wr_w_got, rd_got, b_hs, r_hs;
  logic [ID_W-1:0] seen_awid, seen_arid;
  int         b_count = 0, r_count = 0, viol = 0;
  logic       p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [ADDR_W-1:0] p_awaddr, p_araddr;
  logic [ID_W-1:0]   p_awid, p_arid;
  logic [DATA_W-1:0] p_wdata;
  logic [STRB_W-1:0] p_wstrb;

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RID = 0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    cfg_resp = 0; cfg_rdata = 0; cfg_bad = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awaddr = 0; p_araddr = 0; p_awid = 0; p_arid = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        wr_aw_got = 0; wr_w_got = 0; rd_got = 0; b_hs = 0; r_hs = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        // A pending VALID must stay up with stable payload until its handshake.
        if (p_awv && !p_awr && (AWVALID !== 1'b1 || AWADDR !== p_awaddr || AWID !== p_awid)) viol++;
        if (p_wv && !p_wr && (WVALID !== 1'b1 || WDATA !== p_wdata || WSTRB !== p_wstrb)) viol++;
        if (p_arv && !p_arr && (ARVALID !== 1'b1 || ARADDR !== p_araddr || ARID !== p_arid)) viol++;
        if (BREADY && (AWVALID || WVALID)) viol++;
        if (RREADY && ARVALID) viol++;

        if (b_hs) begin BVALID = 0; wr_aw_got = 0; wr_w_got = 0; b_count++; end
        if (r_hs) begin RVALID = 0; rd_got = 0; r_count++; end

        // Responses are evaluated before this cycle's address/data handshakes
        // are recorded, so B/R never start before those handshakes complete.
        if (wr_aw_got && wr_w_got && !BVALID) begin
          if (b_cnt >= cfg_b) begin
            BVALID = 1; BRESP = cfg_resp; BID = cfg_bad ? ~seen_awid : seen_awid;
          end else b_cnt++;
        end
        if (rd_got && !RVALID) begin
          if (r_cnt >= cfg_r) begin
            RVALID = 1; RDATA = cfg_rdata; RRESP = cfg_resp; RID = cfg_bad ? ~seen_arid : seen_arid;
          end else r_cnt++;
        end

        if (AWVALID) begin AWREADY = (aw_cnt >= cfg_aw); aw_cnt++; end else begin AWREADY = 0; aw_cnt = 0; end
        if (WVALID)  begin WREADY  = (w_cnt  >= cfg_w);  w_cnt++;  end else begin WREADY  = 0; w_cnt  = 0; end
        if (ARVALID) begin ARREADY = (ar_cnt >= cfg_ar); ar_cnt++; end else begin ARREADY = 0; ar_cnt = 0; end

        if (AWVALID && AWREADY) begin wr_aw_got = 1; seen_awid = AWID; b_cnt = 0; end
        if (WVALID && WREADY)   begin wr_w_got = 1; b_cnt = 0; end
        if (ARVALID && ARREADY) begin rd_got = 1; seen_arid = ARID; r_cnt = 0; end
        b_hs = BVALID && BREADY;
        r_hs = RVALID && RREADY;

        p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR; p_awid = AWID;
        p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
        p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR; p_arid = ARID;
      end
    end
  end

  // ---------------- user-side transaction ----------------
  task automatic run_txn(input vec_t v, input string nm);
    int lat, b0, r0;
    bit stable;
    cfg_aw = v.aw_w; cfg_w = v.w_w; cfg_b = v.b_w; cfg_ar = v.ar_w; cfg_r = v.r_w;
    cfg_resp = v.resp; cfg_rdata = v.rdata; cfg_bad = v.bad_id;
    b0 = b_count; r0 = r_count;
    @(negedge ACLK);
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge ACLK); lat++; end
    chk({nm, " req_ready before request"}, req_ready, 1);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(negedge ACLK);
    req_valid = 0;
    chk({nm, " req_ready after accept"}, req_ready, 0);
    if (v.we) begin
      chk({nm, " AW+W issued together"}, {AWVALID, WVALID}, 2'b11);
      chk({nm, " AWADDR"}, AWADDR, v.addr);
      chk({nm, " WDATA"}, WDATA, v.wdata);
      chk({nm, " WSTRB"}, WSTRB, v.wstrb);
      chk({nm, " AWID"}, AWID, v.exp_id);
    end else begin
      chk({nm, " ARVALID"}, ARVALID, 1);
      chk({nm, " ARADDR"}, ARADDR, v.addr);
      chk({nm, " ARID"}, ARID, v.exp_id);
    end
    lat = 1;
    while (!rsp_valid && lat < 80) begin @(negedge ACLK); lat++; end
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " rsp_is_write"}, rsp_is_write, v.exp_wr);
    chk({nm, " rsp_resp"}, rsp_resp, v.exp_resp);
    chk({nm, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    stable = 1;
    for (int k = 0; k < v.hold; k++) begin
      @(negedge ACLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_resp !== v.exp_resp ||
          rsp_is_write !== v.exp_wr || req_ready !== 1'b0) stable = 0;
    end
    chk({nm, " rsp held stable, no req_ready"}, stable, 1);
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
    chk({nm, " rsp_valid after handshake"}, rsp_valid, 0);
    chk({nm, " idle cycle req_ready"}, req_ready, 0);
    @(negedge ACLK);
    chk({nm, " req_ready returns"}, req_ready, 1);
    chk({nm, " B count"}, b_count - b0, v.we ? 1 : 0);
    chk({nm, " R count"}, r_count - r0, v.we ? 0 : 1);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic model_tag;

  initial begin
    tbl[0] = mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 0,0,0,0,0, 3'b000, 32'h0,        0, 0, 32'h0,        3'b000, 1, 3, 0);
    tbl[1] = mk(1, 32'h20,  32'hCAFEF00D, 4'h3, 0,4,0,0,0, 3'b000, 32'h0,        0, 0, 32'h0,        3'b000, 1, 7, 1);
    tbl[2] = mk(0, 32'h30,  32'h0,        4'h0, 0,0,0,3,0, 3'b000, 32'h12345678, 0, 5, 32'h12345678, 3'b000, 0, 6, 0);
    tbl[3] = mk(1, 32'h44,  32'h0BADF00D, 4'hC, 0,0,0,0,0, 3'b010, 32'h0,        0, 0, 32'h0,        3'b010, 1, 3, 1);
    tbl[4] = mk(0, 32'h100, 32'h0,        4'h0, 0,0,0,0,0, 3'b000, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 3'b000, 0, 3, 0);
    tbl[5] = mk(0, 32'h104, 32'h0,        4'h0, 0,0,0,0,0, 3'b000, 32'h55AA55AA, 1, 0, 32'h55AA55AA, 3'b010, 0, 3, 1);
    tbl[6] = mk(1, 32'h200, 32'h11223344, 4'h1, 2,1,2,0,0, 3'b000, 32'h0,        1, 1, 32'h0,        3'b010, 1, 7, 0);
    tbl[7] = mk(0, 32'h300, 32'h0,        4'h0, 0,0,0,1,2, 3'b001, 32'hFEEDFACE, 0, 2, 32'hFEEDFACE, 3'b001, 0, 6, 1);

    ARESETn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge ACLK);
    chk("reset req_ready", req_ready, 0);
    chk("reset valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 6'b0);
    chk("reset addr/id", {AWADDR, ARADDR, AWID, ARID}, 66'h0);
    chk("reset wdata/wstrb", {WDATA, WSTRB}, 36'h0);
    chk("reset rsp fields", {rsp_rdata, rsp_resp, rsp_is_write}, 36'h0);
    ARESETn = 1;
    #1 chk("req_ready before first edge", req_ready, 0);
    @(posedge ACLK);
    #1 chk("req_ready one cycle after reset", req_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write: AW done, W stalled by the worker.
    @(negedge ACLK);
    cfg_aw = 0; cfg_w = 50; cfg_b = 0; cfg_resp = 0; cfg_bad = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h400; req_wdata = 32'h01020304; req_wstrb = 4'hF;
    @(negedge ACLK);
    req_valid = 0;
    @(negedge ACLK);
    chk("midrst WVALID before reset", WVALID, 1);
    chk("midrst WREADY before reset", WREADY, 0);
    chk("midrst AWVALID done", AWVALID, 0);
    #2 ARESETn = 0;
    #1;
    chk("midrst valids drop", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 5'b0);
    chk("midrst no rsp_valid", rsp_valid, 0);
    chk("midrst req_ready low", req_ready, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    #1 chk("midrst req_ready before edge", req_ready, 0);
    @(posedge ACLK);
    #1 chk("midrst req_ready after release", req_ready, 1);
    repeat (3) @(negedge ACLK);
    chk("midrst abandoned, no response", rsp_valid, 0);
    run_txn(mk(0, 32'h500, 32'h0, 4'h0, 0,0,0,0,0, 3'b000, 32'h600DCAFE, 0, 0,
               32'h600DCAFE, 3'b000, 0, 3, 0), "post-reset tag0");

    model_tag = 1;
    for (int i = 0; i < 40; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.addr = $urandom; rv.wdata = $urandom; rv.wstrb = 4'($urandom_range(0, 15));
      rv.aw_w = $urandom_range(0, 3); rv.w_w = $urandom_range(0, 3); rv.b_w = $urandom_range(0, 3);
      rv.ar_w = $urandom_range(0, 3); rv.r_w = $urandom_range(0, 3);
      rv.resp = 3'($urandom_range(0, 7)); rv.rdata = $urandom;
      rv.bad_id = ($urandom_range(0, 4) == 0); rv.hold = $urandom_range(0, 3);
      rv = model(rv, model_tag);
      run_txn(rv, $sformatf("rand%0d", i));
      model_tag = ~model_tag;
    end

    chk("AXI protocol violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
